pwr_seq_ctrl: RTL

Parametrised power-domain sequencer driving the switch, isolation, retention and reset controls of `N_DOM` switchable domains in the UPF test top. It generalises the fixed two-output test top: it services per-domain on/off requests one at a time using round-robin arbitration, applies the isolate → save → switch-off and switch-on → restore → release orderings, and waits for switch acknowledge with a timeout. It sits in the always-on domain, between the test controller and the domain instances.

---
 rtl/pwr_seq_pkg.sv | 28 ++
 rtl/pwr_seq_ctrl_rr_arb.sv | 31 +++
 rtl/pwr_seq_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pwr_seq_pkg.sv
// Shared types for the power-domain sequencer: FSM states, sequence direction
// and a small helper used to size the shared phase/timeout counter.
package pwr_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISO_ON,
    SAVE,
    SW_OFF,
    SW_ON,
    RESTORE,
    RELEASE
  } state_t;

  typedef enum logic {
    OFF,
    ON
  } dir_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/pwr_seq_ctrl_rr_arb.sv
// N-input round-robin arbiter: grants the first request at or after ptr,
// wrapping around; one-hot grant plus valid flag.
module rr_arb #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          valid
);

  localparam int unsigned NU = N;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    for (int unsigned k = 0; k < NU; k++) begin : scan
      int unsigned   j;
      logic [IW-1:0] ji;
      j = k + 32'(ptr);
      if (j >= NU) j = j - NU;
      ji = IW'(j);
      if (!valid && req[ji]) begin
        gnt[ji] = 1'b1;
        valid   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwr_seq_ctrl.sv
// Power-domain sequencer: services per-domain on/off requests one at a time,
// applying isolate/save/switch-off and switch-on/restore/release orderings.
module pwr_seq_ctrl #(
  parameter int N_DOM       = 2,
  parameter int ISO_DLY     = 2,
  parameter int RET_DLY     = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DOM-1:0] req_off,
  input  logic [N_DOM-1:0] pwr_ack,
  input  logic [N_DOM-1:0] err_clr,
  output logic [N_DOM-1:0] pwr_en,
  output logic [N_DOM-1:0] iso_en,
  output logic [N_DOM-1:0] save,
  output logic [N_DOM-1:0] restore,
  output logic [N_DOM-1:0] dom_rst,
  output logic [N_DOM-1:0] dom_on,
  output logic [N_DOM-1:0] err,
  output logic             busy
);

  import pwr_seq_pkg::*;

  localparam int IW = (N_DOM > 1) ? $clog2(N_DOM) : 1;
  localparam int CW = $clog2(max3(ISO_DLY, RET_DLY, ACK_TIMEOUT) + 1);

  state_t         state;
  dir_t           dir;
  logic [IW-1:0]  ptr;
  logic [IW-1:0]  idx;
  logic [CW-1:0]  cnt;

  logic [N_DOM-1:0] cand;
  logic [N_DOM-1:0] gnt;
  logic             arb_valid;
  logic [IW-1:0]    gnt_idx;
  logic [IW-1:0]    ptr_next;

  // A domain needs service when its request disagrees with its current status.
  always_comb begin
    cand = ~(req_off ^ dom_on) & ~err;
  end

  rr_arb #(
    .N  (N_DOM),
    .IW (IW)
  ) u_arb (
    .req   (cand),
    .ptr   (ptr),
    .gnt   (gnt),
    .valid (arb_valid)
  );

  always_comb begin
    gnt_idx = '0;
    for (int unsigned k = 0; k < N_DOM; k++) begin
      if (gnt[k]) gnt_idx = IW'(k);
    end
    ptr_next = (gnt_idx == IW'(N_DOM - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      dir     <= OFF;
      ptr     <= '0;
      idx     <= '0;
      cnt     <= '0;
      pwr_en  <= '1;
      iso_en  <= '0;
      save    <= '0;
      restore <= '0;
      dom_rst <= '0;
      dom_on  <= '1;
      err     <= '0;
      busy    <= 1'b0;
    end else begin
      save    <= '0;
      restore <= '0;
      // Clear first so a coincident timeout assignment below takes priority.
      err     <= err & ~err_clr;

      case (state)
        IDLE: begin
          if (arb_valid) begin
            idx  <= gnt_idx;
            ptr  <= ptr_next;
            cnt  <= '0;
            busy <= 1'b1;
            if (req_off[gnt_idx]) begin
              dir             <= OFF;
              state           <= ISO_ON;
              iso_en[gnt_idx] <= 1'b1;
            end else begin
              dir             <= ON;
              state           <= SW_ON;
              pwr_en[gnt_idx] <= 1'b1;
            end
          end
        end

        ISO_ON: begin
          if (cnt == CW'(ISO_DLY - 1)) begin
            state     <= SAVE;
            cnt       <= '0;
            save[idx] <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        SAVE: begin
          if (cnt == CW'(RET_DLY - 1)) begin
            state       <= SW_OFF;
            cnt         <= '0;
            pwr_en[idx] <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Both switch waits share one body; dir selects the expected ack level.
        SW_OFF, SW_ON: begin
          if (pwr_ack[idx] == (dir == ON)) begin
            if (dir == OFF) begin
              dom_rst[idx] <= 1'b1;
              dom_on[idx]  <= 1'b0;
              state        <= IDLE;
              busy         <= 1'b0;
            end else begin
              state        <= RESTORE;
              cnt          <= '0;
              restore[idx] <= 1'b1;
            end
          end else if (cnt == CW'(ACK_TIMEOUT)) begin
            err[idx]     <= 1'b1;
            iso_en[idx]  <= 1'b1;
            dom_rst[idx] <= 1'b1;
            dom_on[idx]  <= 1'b0;
            state        <= IDLE;
            busy         <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RESTORE: begin
          if (cnt == CW'(RET_DLY - 1)) begin
            state        <= RELEASE;
            cnt          <= '0;
            dom_rst[idx] <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RELEASE: begin
          if (cnt == CW'(ISO_DLY - 1)) begin
            iso_en[idx] <= 1'b0;
            dom_on[idx] <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
